fib_sequencer: RTL and testbench
================================

Name: fib_sequencer

Overview:
Iterative Fibonacci sequencer that sits directly upstream of the datapath ALU. It owns the counter and the operand registers, drives the ALU opcode and operands, and consumes the ALU result and zero flag. On start it computes F(n) for an unsigned n (F(0)=0, F(1)=1) and presents the result with a one-cycle done pulse.

Parameters:
size, 4, data width of n, the operand registers, result and the ALU operands/result

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
n  in  size  Fibonacci index; latched when start is accepted
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE
result  out  size  F(n) mod 2^size; valid from DONE until the next accepted start
overflow  out  1  sticky; set if any ADD wrapped during this run
alu_opcode  out  3  ALU operation code
alu_a  out  size  ALU operand A
alu_b  out  size  ALU operand B
alu_o  in  size  ALU result; combinational within the same cycle
alu_zero  in  1  ALU zero flag; combinational within the same cycle

Behaviour:
- Single clock domain. rst_n is asynchronous and active-low.
- Reset, whether asserted or applied mid-run, forces the following:
  - state=IDLE
  - cnt=0, r0=0, r1=0
  - result=0, overflow=0, done=0, busy=0
  - alu_opcode=000
- Opcodes are shared constants:
  - NOP=000
  - SET=001 (O=1)
  - DEC=011 (O=A-1)
  - LOAD=101 (O=A)
  - ADD=110 (O=A+B)
- Moore outputs: alu_opcode, alu_a and alu_b are decoded from the state register only.
- alu_o and alu_zero are sampled on the rising edge that ends each state.
- ALU constraint: the ALU re-evaluates only when its opcode changes, so the opcode must differ between any two consecutive sampling states. The state sequence below guarantees this; an implementation must not insert repeated-opcode states.
- States and transitions:
  - IDLE: opcode NOP. On start=1: cnt<=n, overflow<=0, result<=0, go to CHK. Otherwise stay in IDLE.
  - CHK: opcode LOAD, alu_a=cnt. If alu_zero=1: result<=0, go to DONE. Otherwise go to INIT.
  - INIT: opcode SET. r1<=alu_o (=1), r0<=0, go to DEC.
  - DEC: opcode DEC, alu_a=cnt. cnt<=alu_o. If alu_zero=1: result<=r1, go to DONE. Otherwise go to ADD.
  - ADD: opcode ADD, alu_a=r0, alu_b=r1. r0<=r1, r1<=alu_o. If alu_o<r1 (unsigned wrap): overflow<=1. Go to DEC.
  - DONE: opcode NOP, done=1, busy=1. Next state is IDLE unconditionally.
- alu_a and alu_b are 0 in states that do not use them.
- Latency, counting the accepting edge as edge 0:
  - n=0: DONE in cycle 2.
  - n>=1: the run executes n DEC and n-1 ADD states; DONE in cycle 2n+2.
- start while busy is ignored, and n changes while busy are ignored.
- start held high continuously restarts on the IDLE cycle after DONE.
- n = 2^size-1 must complete without a counter wrap; cnt only decrements until zero.
- result and overflow are stable from DONE until the next accepted start.

Decomposition:
- Shared package: opcode constants (NOP, SET, DEC, LOAD, ADD) and the state encoding (IDLE, CHK, INIT, DEC, ADD, DONE; 3 bits).
- Sub-module: fib_reg, a size-wide register with async active-low clear and load enable. It is instantiated for cnt, r0, r1 and result.
- The FSM and output decode stay in fib_sequencer.
- The bench pairs the block with a behavioural ALU model that updates only on opcode change, to catch repeated-opcode sequencing.

Test Plan:
1. Reset mid-run (assert rst_n=0 in the 3rd DEC for n=6) -> all outputs 0 immediately, without waiting for clk; after release, IDLE with opcode 000.
2. n=0, start pulse -> opcode sequence 101 then 000; done in cycle 2; result=0; overflow=0.
3. n=1 -> opcodes 101,001,011; done in cycle 4; result=1.
4. n=7, size=4 -> done in cycle 16; result=13; overflow=0; opcode never repeats in consecutive cycles from CHK to DONE.
5. n=8, size=4 -> result=5 (21 mod 16); overflow=1. Then a second run with n=3 -> result=2 and overflow cleared to 0.
6. start pulsed in the 5th cycle of a run, with n changed to 2 -> ignored; original result unaffected. start held high -> new run accepted on the IDLE cycle after done.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci sequencer: ALU opcodes and FSM state encoding.
package fib_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_SET  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHK  = 3'd1,
    S_INIT = 3'd2,
    S_DEC  = 3'd3,
    S_ADD  = 3'd4,
    S_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/fib_reg.sv
// Width-parameterised register with asynchronous active-low clear and load enable.
module fib_reg #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [size-1:0] d,
  output logic [size-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fib_sequencer.sv
// Iterative Fibonacci sequencer driving an external ALU; computes F(n) mod 2^size.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [size-1:0] n,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] result,
  output logic            overflow,
  output logic [2:0]      alu_opcode,
  output logic [size-1:0] alu_a,
  output logic [size-1:0] alu_b,
  input  logic [size-1:0] alu_o,
  input  logic            alu_zero
);

  state_t state, state_nxt;

  logic [size-1:0] cnt, r0, r1;
  logic [size-1:0] cnt_d, r0_d, r1_d, res_d;
  logic            cnt_en, r0_en, r1_en, res_en;
  logic            ovf_nxt;

  fib_reg #(.size(size)) u_cnt (.clk(clk), .rst_n(rst_n), .en(cnt_en), .d(cnt_d), .q(cnt));
  fib_reg #(.size(size)) u_r0  (.clk(clk), .rst_n(rst_n), .en(r0_en),  .d(r0_d),  .q(r0));
  fib_reg #(.size(size)) u_r1  (.clk(clk), .rst_n(rst_n), .en(r1_en),  .d(r1_d),  .q(r1));
  fib_reg #(.size(size)) u_res (.clk(clk), .rst_n(rst_n), .en(res_en), .d(res_d), .q(result));

  // NOTE: every control register, not just the state, is cleared by the async
  // reset so a mid-run reset leaves no stale result or overflow visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      overflow <= ovf_nxt;
    end
  end

  // NOTE: all outputs of a combinational process get a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    r0_en     = 1'b0;
    r1_en     = 1'b0;
    res_en    = 1'b0;
    cnt_d     = '0;
    r0_d      = '0;
    r1_d      = '0;
    res_d     = '0;
    ovf_nxt   = overflow;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          cnt_en    = 1'b1;
          cnt_d     = n;
          res_en    = 1'b1;
          ovf_nxt   = 1'b0;
          state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (alu_zero) begin
          res_en    = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        r1_en     = 1'b1;
        r1_d      = alu_o;
        r0_en     = 1'b1;
        state_nxt = S_DEC;
      end
      S_DEC: begin
        // cnt stops at zero: the zero flag ends the run before another DEC.
        cnt_en = 1'b1;
        cnt_d  = alu_o;
        if (alu_zero) begin
          res_en    = 1'b1;
          res_d     = r1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        r0_en     = 1'b1;
        r0_d      = r1;
        r1_en     = 1'b1;
        r1_d      = alu_o;
        // An unsigned sum smaller than an addend means the add wrapped.
        if (alu_o < r1) ovf_nxt = 1'b1;
        state_nxt = S_DEC;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore output decode: depends only on the state register and operand registers.
  always_comb begin
    alu_opcode = OP_NOP;
    alu_a      = '0;
    alu_b      = '0;
    unique case (state)
      S_CHK: begin
        alu_opcode = OP_LOAD;
        alu_a      = cnt;
      end
      S_INIT: alu_opcode = OP_SET;
      S_DEC: begin
        alu_opcode = OP_DEC;
        alu_a      = cnt;
      end
      S_ADD: begin
        alu_opcode = OP_ADD;
        alu_a      = r0;
        alu_b      = r1;
      end
      default: alu_opcode = OP_NOP;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_fib_sequencer.sv
// Self-checking bench: scoreboard of expected runs plus a behavioural ALU that updates only on opcode change.
module tb_fib_sequencer;

  localparam int SIZE = 4;

  typedef struct {
    int             nn;
    logic [SIZE-1:0] res;
    logic           ovf;
    int             cycles;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [SIZE-1:0] n;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] result;
  logic            overflow;
  logic [2:0]      alu_opcode;
  logic [SIZE-1:0] alu_a;
  logic [SIZE-1:0] alu_b;
  logic [SIZE-1:0] alu_o;
  logic            alu_zero;

  int checks   = 0;
  int failures = 0;

  exp_t       sb[$];
  logic [2:0] ops_q[$];

  fib_sequencer #(.size(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n),
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_zero(alu_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ALU that re-evaluates only when the opcode changes; operands are read
  // shortly after the change once the sequencer's registers have settled.
  initial begin
    alu_o    = '0;
    alu_zero = 1'b1;
    forever begin
      @(alu_opcode);
      #1;
      case (alu_opcode)
        3'b001:  alu_o = 4'd1;
        3'b011:  alu_o = alu_a - 4'd1;
        3'b101:  alu_o = alu_a;
        3'b110:  alu_o = alu_a + alu_b;
        default: alu_o = '0;
      endcase
      alu_zero = (alu_o == '0);
    end
  end

  function automatic exp_t model(input int nn);
    exp_t e;
    int a, b, t;
    a = 0;
    b = 1;
    if (nn == 0) b = 0;
    else for (int k = 1; k < nn; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    e.nn     = nn;
    e.res    = SIZE'(b % (1 << SIZE));
    e.ovf    = (b >= (1 << SIZE));
    e.cycles = (nn == 0) ? 2 : 2 * nn + 2;
    return e;
  endfunction

  // Drive a start in an IDLE cycle and record the expected outcome at the accepting edge.
  task automatic start_run(input logic [SIZE-1:0] nn);
    @(negedge clk);
    start = 1'b1;
    n     = nn;
    @(posedge clk);
    sb.push_back(model(int'(nn)));
  endtask

  // Follow a run cycle by cycle (cycle 1 = state after the accepting edge) until done.
  task automatic wait_done(input bit hold, input int glitch_cyc, input logic [SIZE-1:0] glitch_n,
                           output int cyc, output bit timed_out);
    cyc       = 0;
    timed_out = 1'b0;
    ops_q.delete();
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !hold) start = 1'b0;
      if (cyc == glitch_cyc) begin
        start = 1'b1;
        n     = glitch_n;
      end
      if (glitch_cyc > 0 && cyc == glitch_cyc + 1) start = 1'b0;
      ops_q.push_back(alu_opcode);
      if (done) break;
      if (cyc >= 200) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    start = 1'b0;
    n     = '0;
    #12;
    checks++;
    if ({busy, done, result, overflow, alu_opcode, alu_a, alu_b} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%0d ovf=%b op=%b a=%0d b=%0d expected all 0",
               busy, done, result, overflow, alu_opcode, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-run reset during the third DEC of an n=6 run.
    start_run(4'd6);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    checks++;
    if (alu_opcode !== 3'b011) begin
      failures++;
      $display("FAIL reset_third_dec_op: got %b expected 011", alu_opcode);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, overflow, alu_opcode, alu_a, alu_b} !== '0) begin
      failures++;
      $display("FAIL midrun_reset_outputs: got busy=%b done=%b result=%0d ovf=%b op=%b a=%0d b=%0d expected all 0",
               busy, done, result, overflow, alu_opcode, alu_a, alu_b);
    end
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || alu_opcode !== 3'b000) begin
      failures++;
      $display("FAIL reset_release_idle: got busy=%b op=%b expected busy=0 op=000", busy, alu_opcode);
    end
  endtask

  task automatic test_n0();
    exp_t e;
    int cyc;
    bit to;
    start_run(4'd0);
    wait_done(1'b0, 0, '0, cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || cyc !== e.cycles) begin
      failures++;
      $display("FAIL n0_latency: got cycle %0d (timeout=%b) expected %0d", cyc, to, e.cycles);
    end
    checks++;
    if (ops_q.size() != 2 || ops_q[0] !== 3'b101 || ops_q[1] !== 3'b000) begin
      failures++;
      $display("FAIL n0_opcodes: got %0d ops first=%b expected 101,000", ops_q.size(), ops_q[0]);
    end
    checks++;
    if (result !== e.res || overflow !== e.ovf) begin
      failures++;
      $display("FAIL n0_result: got %0d ovf=%b expected %0d ovf=%b", result, overflow, e.res, e.ovf);
    end
  endtask

  task automatic test_n1();
    exp_t e;
    int cyc;
    bit to;
    start_run(4'd1);
    wait_done(1'b0, 0, '0, cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || cyc !== e.cycles) begin
      failures++;
      $display("FAIL n1_latency: got cycle %0d (timeout=%b) expected %0d", cyc, to, e.cycles);
    end
    checks++;
    if (ops_q.size() < 3 || ops_q[0] !== 3'b101 || ops_q[1] !== 3'b001 || ops_q[2] !== 3'b011) begin
      failures++;
      $display("FAIL n1_opcodes: got %0d ops expected 101,001,011,000", ops_q.size());
    end
    checks++;
    if (result !== e.res || overflow !== e.ovf) begin
      failures++;
      $display("FAIL n1_result: got %0d ovf=%b expected %0d ovf=%b", result, overflow, e.res, e.ovf);
    end
  endtask

  task automatic test_n7();
    exp_t e;
    int cyc;
    bit to;
    int repeats;
    start_run(4'd7);
    wait_done(1'b0, 0, '0, cyc, to);
    e = sb.pop_front();
    repeats = 0;
    for (int i = 1; i < ops_q.size(); i++)
      if (ops_q[i] == ops_q[i-1]) repeats++;
    checks++;
    if (to || cyc !== e.cycles) begin
      failures++;
      $display("FAIL n7_latency: got cycle %0d (timeout=%b) expected %0d", cyc, to, e.cycles);
    end
    checks++;
    if (repeats !== 0) begin
      failures++;
      $display("FAIL n7_opcode_repeat: got %0d repeats expected 0", repeats);
    end
    checks++;
    if (result !== e.res || overflow !== e.ovf) begin
      failures++;
      $display("FAIL n7_result: got %0d ovf=%b expected %0d ovf=%b", result, overflow, e.res, e.ovf);
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    int cyc;
    bit to;
    logic [SIZE-1:0] nv[3];
    nv[0] = 4'd8;
    nv[1] = 4'd3;
    nv[2] = 4'd15;
    foreach (nv[k]) begin
      start_run(nv[k]);
      wait_done(1'b0, 0, '0, cyc, to);
      e = sb.pop_front();
      checks++;
      if (to || cyc !== e.cycles) begin
        failures++;
        $display("FAIL ovf_latency n=%0d: got cycle %0d (timeout=%b) expected %0d", e.nn, cyc, to, e.cycles);
      end
      checks++;
      if (result !== e.res || overflow !== e.ovf) begin
        failures++;
        $display("FAIL ovf_result n=%0d: got %0d ovf=%b expected %0d ovf=%b", e.nn, result, overflow, e.res, e.ovf);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || result !== e.res || overflow !== e.ovf) begin
        failures++;
        $display("FAIL ovf_hold n=%0d: got busy=%b %0d ovf=%b expected busy=0 %0d ovf=%b",
                 e.nn, busy, result, overflow, e.res, e.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    bit to;
    // start pulsed mid-run with a new n must not disturb the run.
    start_run(4'd5);
    wait_done(1'b0, 5, 4'd2, cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || cyc !== e.cycles || result !== e.res || overflow !== e.ovf) begin
      failures++;
      $display("FAIL ignore_start: got cycle %0d %0d ovf=%b expected cycle %0d %0d ovf=%b",
               cyc, result, overflow, e.cycles, e.res, e.ovf);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_idle: got busy=%b expected 0", busy);
    end

    // start held high: restart on the IDLE cycle after DONE.
    start_run(4'd3);
    wait_done(1'b1, 0, '0, cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || cyc !== e.cycles || result !== e.res) begin
      failures++;
      $display("FAIL held_first: got cycle %0d %0d expected cycle %0d %0d", cyc, result, e.cycles, e.res);
    end
    n = 4'd4;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || alu_opcode !== 3'b000) begin
      failures++;
      $display("FAIL held_idle_gap: got busy=%b op=%b expected busy=0 op=000", busy, alu_opcode);
    end
    @(posedge clk);
    sb.push_back(model(4));
    wait_done(1'b0, 0, '0, cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || cyc !== e.cycles || result !== e.res || overflow !== e.ovf) begin
      failures++;
      $display("FAIL held_restart: got cycle %0d %0d ovf=%b expected cycle %0d %0d ovf=%b",
               cyc, result, overflow, e.cycles, e.res, e.ovf);
    end
  endtask

  initial begin
    test_reset();
    test_n0();
    test_n1();
    test_n7();
    test_overflow();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
